// File: rtl/nx_aggregator_pkg.sv
`default_nettype none
// ============================================================================
// Module      : NXConstants (package)
// Description : Nexus mesh message types, field widths and arbiter slot indices.
// Revision    : 1.0 - initial release
// ============================================================================
package NXConstants;

    localparam int ID_ROW_WIDTH     = 4;
    localparam int ID_COL_WIDTH     = 4;
    localparam int COMMAND_WIDTH    = 3;
    localparam int INDEX_WIDTH      = 7;
    localparam int MESSAGE_WIDTH    = 32;
    localparam int HEADER_WIDTH     = ID_ROW_WIDTH + ID_COL_WIDTH + COMMAND_WIDTH;
    localparam int PAYLOAD_WIDTH    = MESSAGE_WIDTH - HEADER_WIDTH;
    localparam int SIGNAL_PAD_WIDTH = PAYLOAD_WIDTH - INDEX_WIDTH - 1;

    // Arbiter request/grant bit positions
    localparam int ARB_PASS = 0;
    localparam int ARB_IN   = 1;

    typedef struct packed {
        logic [ID_ROW_WIDTH-1:0] row;
        logic [ID_COL_WIDTH-1:0] column;
    } node_id_t;

    typedef enum logic [COMMAND_WIDTH-1:0] {
        NODE_COMMAND_LOAD     = 3'd0,
        NODE_COMMAND_LOOPBACK = 3'd1,
        NODE_COMMAND_SIGNAL   = 3'd2,
        NODE_COMMAND_TRACE    = 3'd3
    } node_command_t;

    typedef struct packed {
        logic [ID_ROW_WIDTH-1:0] row;
        logic [ID_COL_WIDTH-1:0] column;
        node_command_t           command;
    } node_header_t;

    typedef struct packed {
        node_header_t             header;
        logic [PAYLOAD_WIDTH-1:0] payload;
    } node_message_t;

    // Payload view of a SIGNAL message
    typedef struct packed {
        node_header_t                header;
        logic [INDEX_WIDTH-1:0]      index;
        logic                        state;
        logic [SIGNAL_PAD_WIDTH-1:0] padding;
    } node_signal_t;

endpackage : NXConstants
`default_nettype wire

// File: rtl/nx_aggregator_arb.sv
`default_nettype none
// ============================================================================
// Module      : nx_aggregator_arb
// Description : Two-way round-robin arbiter; priority moves only on a transfer.
// Revision    : 1.0 - initial release
// ============================================================================
module nx_aggregator_arb
    import NXConstants::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [1:0] i_req,
    input  logic       i_fire,
    output logic [1:0] o_grant
);

    // High when passthrough wins a tie; starts on the passthrough side
    logic r_prio_pass;

    always_comb begin
        o_grant = 2'b00;
        if (i_req[ARB_PASS] && (!i_req[ARB_IN] || r_prio_pass)) begin
            o_grant[ARB_PASS] = 1'b1;
        end else if (i_req[ARB_IN]) begin
            o_grant[ARB_IN] = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_prio_pass <= 1'b1;
        end else if (i_fire) begin
            r_prio_pass <= o_grant[ARB_IN];
        end
    end

endmodule : nx_aggregator_arb
`default_nettype wire

// File: rtl/nx_aggregator.sv
`default_nettype none
// ============================================================================
// Module      : nx_aggregator
// Description : Nexus mesh edge aggregator - captures local SIGNAL messages into
//               an output vector and forwards all other traffic outbound.
// Revision    : 1.0 - initial release
// ============================================================================
module nx_aggregator
    import NXConstants::*;
#(
    parameter int OUTPUTS = 32
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  node_id_t           i_node_id,
    output logic               o_idle,
    output logic [OUTPUTS-1:0] o_outputs,
    input  node_message_t      i_inbound_data,
    input  logic               i_inbound_valid,
    output logic               o_inbound_ready,
    input  node_message_t      i_passthrough_data,
    input  logic               i_passthrough_valid,
    output logic               o_passthrough_ready,
    output node_message_t      o_outbound_data,
    output logic               o_outbound_valid,
    input  logic               i_outbound_ready
);

    node_signal_t       w_sig;
    logic               w_unused_pad;
    logic               w_local;
    logic               w_local_fire;
    logic [31:0]        w_index;
    logic [1:0]         w_req;
    logic [1:0]         w_grant;
    logic               w_slot_free;
    logic               w_fire;
    logic [OUTPUTS-1:0] w_outputs_next;

    logic [OUTPUTS-1:0] r_outputs;
    node_message_t      r_out_data;
    logic               r_out_valid;

    assign w_sig        = i_inbound_data;
    assign w_unused_pad = ^w_sig.padding;
    assign w_index      = 32'(w_sig.index);

    assign w_local = (w_sig.header.row == i_node_id.row)
                  && (w_sig.header.column == i_node_id.column)
                  && (w_sig.header.command == NODE_COMMAND_SIGNAL);
    assign w_local_fire = i_inbound_valid && w_local;

    assign w_req[ARB_PASS] = i_passthrough_valid;
    assign w_req[ARB_IN]   = i_inbound_valid && !w_local;

    assign w_slot_free = !r_out_valid || i_outbound_ready;
    assign w_fire      = w_slot_free && (|w_req);

    nx_aggregator_arb u_arb (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_req   (w_req),
        .i_fire  (w_fire),
        .o_grant (w_grant)
    );

    assign o_passthrough_ready = w_slot_free && w_grant[ARB_PASS];
    assign o_inbound_ready     = w_local || (w_slot_free && w_grant[ARB_IN]);

    // Out-of-range indices match no bit, so such messages drop silently
    always_comb begin
        w_outputs_next = r_outputs;
        for (int i = 0; i < OUTPUTS; i++) begin
            if (w_local_fire && (w_index == 32'(i))) begin
                w_outputs_next[i] = w_sig.state;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_outputs <= '0;
        end else begin
            r_outputs <= w_outputs_next;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else if (w_fire) begin
            r_out_data  <= w_grant[ARB_PASS] ? i_passthrough_data : i_inbound_data;
            r_out_valid <= 1'b1;
        end else if (i_outbound_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign o_outputs        = r_outputs;
    assign o_outbound_data  = r_out_data;
    assign o_outbound_valid = r_out_valid;
    assign o_idle           = !i_inbound_valid && !i_passthrough_valid && !r_out_valid;

endmodule : nx_aggregator
`default_nettype wire

// File: tb/tb_nx_aggregator.sv
`default_nettype none
// ============================================================================
// Module      : tb_nx_aggregator
// Description : Directed plus randomized bench for nx_aggregator with a queue
//               based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nx_aggregator;
    import NXConstants::*;

    localparam int OUTPUTS = 32;

    logic               i_clk = 1'b0;
    logic               i_rst;
    node_id_t           i_node_id;
    logic               o_idle;
    logic [OUTPUTS-1:0] o_outputs;
    node_message_t      i_inbound_data;
    logic               i_inbound_valid;
    logic               o_inbound_ready;
    node_message_t      i_passthrough_data;
    logic               i_passthrough_valid;
    logic               o_passthrough_ready;
    node_message_t      o_outbound_data;
    logic               o_outbound_valid;
    logic               i_outbound_ready;

    nx_aggregator #(.OUTPUTS(OUTPUTS)) dut (
        .i_clk               (i_clk),
        .i_rst               (i_rst),
        .i_node_id           (i_node_id),
        .o_idle              (o_idle),
        .o_outputs           (o_outputs),
        .i_inbound_data      (i_inbound_data),
        .i_inbound_valid     (i_inbound_valid),
        .o_inbound_ready     (o_inbound_ready),
        .i_passthrough_data  (i_passthrough_data),
        .i_passthrough_valid (i_passthrough_valid),
        .o_passthrough_ready (o_passthrough_ready),
        .o_outbound_data     (o_outbound_data),
        .o_outbound_valid    (o_outbound_valid),
        .i_outbound_ready    (i_outbound_ready)
    );

    always #5 i_clk = ~i_clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state
    logic [OUTPUTS-1:0] m_outputs;
    bit                 m_ov;
    node_message_t      m_od;
    bit                 m_prio_pass;
    bit                 p_hold, i_hold;
    node_message_t      pass_q[$];
    node_message_t      in_q[$];
    node_message_t      got_q[$];
    logic               obs_ir, obs_pr, obs_idle;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic node_message_t mk_sig(int r, int c, int idx, bit st);
        node_signal_t s;
        s                = '0;
        s.header.row     = ID_ROW_WIDTH'(r);
        s.header.column  = ID_COL_WIDTH'(c);
        s.header.command = NODE_COMMAND_SIGNAL;
        s.index          = INDEX_WIDTH'(idx);
        s.state          = st;
        s.padding        = SIGNAL_PAD_WIDTH'($urandom);
        return node_message_t'(s);
    endfunction

    function automatic node_message_t mk_raw(int r, int c, node_command_t cmd);
        node_message_t m;
        m.header.row     = ID_ROW_WIDTH'(r);
        m.header.column  = ID_COL_WIDTH'(c);
        m.header.command = cmd;
        m.payload        = PAYLOAD_WIDTH'($urandom);
        return m;
    endfunction

    function automatic node_message_t rand_msg();
        int sel;
        sel = $urandom_range(0, 3);
        if (sel == 0) return mk_sig(2, 3, $urandom_range(0, 40), 1'($urandom));
        if (sel == 1) return mk_raw(2, 3, node_command_t'(3'($urandom_range(3, 7))));
        return node_message_t'($urandom);
    endfunction

    function automatic bit tb_is_local(node_message_t m);
        return (m.header.row == i_node_id.row) && (m.header.column == i_node_id.column)
            && (m.header.command == NODE_COMMAND_SIGNAL);
    endfunction

    task automatic model_reset();
        m_outputs   = '0;
        m_ov        = 1'b0;
        m_od        = '0;
        m_prio_pass = 1'b1;
        p_hold      = 1'b0;
        i_hold      = 1'b0;
        pass_q.delete();
        in_q.delete();
        got_q.delete();
    endtask

    // One clock cycle: present queue heads, check handshake outputs, advance model, check state
    task automatic step(input bit pv_en, input bit iv_en, input bit out_rdy);
        bit           is_loc, slot, req_p, req_i, win_p, win_i, exp_pr, exp_ir;
        node_signal_t s;
        @(negedge i_clk);
        i_passthrough_valid = (pass_q.size() > 0) && (p_hold || pv_en);
        if (i_passthrough_valid) i_passthrough_data = pass_q[0];
        i_inbound_valid = (in_q.size() > 0) && (i_hold || iv_en);
        if (i_inbound_valid) i_inbound_data = in_q[0];
        i_outbound_ready = out_rdy;
        #1;
        is_loc = tb_is_local(i_inbound_data);
        slot   = !m_ov || out_rdy;
        req_p  = i_passthrough_valid;
        req_i  = i_inbound_valid && !is_loc;
        win_p  = req_p && (!req_i || m_prio_pass);
        win_i  = req_i && !win_p;
        exp_pr = slot && win_p;
        exp_ir = is_loc || (slot && win_i);
        obs_ir   = o_inbound_ready;
        obs_pr   = o_passthrough_ready;
        obs_idle = o_idle;
        chk("passthrough_ready", 64'(o_passthrough_ready), 64'(exp_pr));
        chk("inbound_ready", 64'(o_inbound_ready), 64'(exp_ir));
        chk("idle", 64'(o_idle), 64'(!i_inbound_valid && !i_passthrough_valid && !m_ov));
        if (m_ov && out_rdy) got_q.push_back(o_outbound_data);

        if (i_inbound_valid && is_loc) begin
            s = i_inbound_data;
            if (int'(s.index) < OUTPUTS) m_outputs[int'(s.index)] = s.state;
        end
        if (slot && (win_p || win_i)) begin
            m_od        = win_p ? i_passthrough_data : i_inbound_data;
            m_ov        = 1'b1;
            m_prio_pass = win_i;
        end else if (out_rdy) begin
            m_ov = 1'b0;
        end
        p_hold = i_passthrough_valid && !exp_pr;
        i_hold = i_inbound_valid && !exp_ir;
        if (i_passthrough_valid && exp_pr) void'(pass_q.pop_front());
        if (i_inbound_valid && exp_ir) void'(in_q.pop_front());

        @(posedge i_clk);
        #1;
        chk("outputs", 64'(o_outputs), 64'(m_outputs));
        chk("outbound_valid", 64'(o_outbound_valid), 64'(m_ov));
        if (m_ov) chk("outbound_data", 64'(o_outbound_data), 64'(m_od));
    endtask

    // Asynchronous reset: outputs must clear before any clock edge
    task automatic do_reset();
        @(negedge i_clk);
        i_rst               = 1'b0;
        i_inbound_valid     = 1'b0;
        i_passthrough_valid = 1'b0;
        #1;
        chk("rst_outputs", 64'(o_outputs), 64'd0);
        chk("rst_outbound_valid", 64'(o_outbound_valid), 64'd0);
        chk("rst_outbound_data", 64'(o_outbound_data), 64'd0);
        chk("rst_idle", 64'(o_idle), 64'd1);
        @(negedge i_clk);
        i_rst = 1'b1;
        model_reset();
        #1;
        chk("post_rst_idle", 64'(o_idle), 64'd1);
    endtask

    initial begin : main
        node_message_t a, b, c, d, e, m1, m2;
        int            guard;
        i_rst               = 1'b1;
        i_node_id.row       = 4'd2;
        i_node_id.column    = 4'd3;
        i_inbound_data      = '0;
        i_inbound_valid     = 1'b0;
        i_passthrough_data  = '0;
        i_passthrough_valid = 1'b0;
        i_outbound_ready    = 1'b1;
        model_reset();

        // 1. Reset
        do_reset();

        // 2. Local signal set then clear
        in_q.push_back(mk_sig(2, 3, 5, 1'b1));
        step(0, 1, 1);
        chk("t2_ready", 64'(obs_ir), 64'd1);
        chk("t2_outputs_set", 64'(o_outputs), 64'h20);
        chk("t2_no_forward", 64'(o_outbound_valid), 64'd0);
        in_q.push_back(mk_sig(2, 3, 5, 1'b0));
        step(0, 1, 1);
        chk("t2_outputs_clr", 64'(o_outputs), 64'h0);

        // 3. Out-of-range index is dropped
        in_q.push_back(mk_sig(2, 3, 5, 1'b1));
        step(0, 1, 1);
        in_q.push_back(mk_sig(2, 3, 40, 1'b1));
        step(0, 1, 1);
        chk("t3_ready", 64'(obs_ir), 64'd1);
        chk("t3_outputs", 64'(o_outputs), 64'h20);

        // 4. Forwarding and backpressure
        m1 = mk_raw(0, 1, NODE_COMMAND_LOAD);
        in_q.push_back(m1);
        step(0, 1, 1);
        chk("t4_fwd_valid", 64'(o_outbound_valid), 64'd1);
        chk("t4_fwd_data", 64'(o_outbound_data), 64'(m1));
        step(0, 0, 1);
        m1 = mk_raw(0, 1, NODE_COMMAND_TRACE);
        m2 = mk_raw(1, 1, NODE_COMMAND_LOOPBACK);
        in_q.push_back(m1);
        in_q.push_back(m2);
        step(0, 1, 0);
        step(0, 1, 0);
        chk("t4_stall_ready", 64'(obs_ir), 64'd0);
        chk("t4_held_data", 64'(o_outbound_data), 64'(m1));
        step(0, 1, 0);
        chk("t4_still_held", 64'(o_outbound_data), 64'(m1));
        step(0, 1, 1);
        chk("t4_second", 64'(o_outbound_data), 64'(m2));
        step(0, 0, 1);

        // 5. Round-robin contention from a fresh pointer
        do_reset();
        a = mk_raw(5, 5, NODE_COMMAND_LOAD);
        b = mk_raw(6, 6, NODE_COMMAND_LOAD);
        c = mk_raw(7, 7, NODE_COMMAND_TRACE);
        d = mk_raw(8, 8, NODE_COMMAND_TRACE);
        pass_q.push_back(a);
        pass_q.push_back(b);
        in_q.push_back(c);
        in_q.push_back(d);
        for (int i = 0; i < 5; i++) step(1, 1, 1);
        chk("t5_count", 64'(got_q.size()), 64'd4);
        if (got_q.size() == 4) begin
            chk("t5_first_A", 64'(got_q[0]), 64'(a));
            chk("t5_second_C", 64'(got_q[1]), 64'(c));
            chk("t5_third_B", 64'(got_q[2]), 64'(b));
            chk("t5_fourth_D", 64'(got_q[3]), 64'(d));
        end

        // 6. Local signal concurrent with passthrough forward
        e = mk_raw(2, 3, NODE_COMMAND_LOOPBACK);
        in_q.push_back(mk_sig(2, 3, 9, 1'b1));
        pass_q.push_back(e);
        step(1, 1, 0);
        chk("t6_in_ready", 64'(obs_ir), 64'd1);
        chk("t6_pass_ready", 64'(obs_pr), 64'd1);
        chk("t6_outputs", 64'(o_outputs), 64'h200);
        chk("t6_pass_data", 64'(o_outbound_data), 64'(e));
        step(0, 0, 0);
        chk("t6_busy", 64'(obs_idle), 64'd0);
        step(0, 0, 1);
        step(0, 0, 1);
        chk("t6_drained_idle", 64'(obs_idle), 64'd1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            if (pass_q.size() < 4 && $urandom_range(0, 1) == 1) pass_q.push_back(rand_msg());
            if (in_q.size() < 4 && $urandom_range(0, 1) == 1) in_q.push_back(rand_msg());
            step(1'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0));
        end
        guard = 0;
        while ((pass_q.size() > 0 || in_q.size() > 0 || m_ov) && guard < 40) begin
            step(1, 1, 1);
            guard++;
        end
        chk("random_drained", 64'(pass_q.size() + in_q.size() + int'(m_ov)), 64'd0);

        // Reset mid-operation drops a held message
        pass_q.push_back(mk_raw(1, 2, NODE_COMMAND_LOAD));
        in_q.push_back(mk_sig(2, 3, 31, 1'b1));
        step(1, 1, 0);
        chk("pre_rst_valid", 64'(o_outbound_valid), 64'd1);
        do_reset();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_nx_aggregator
`default_nettype wire
